// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the magnetron control block: FSM state encoding,
// the default synchronizer depth and the inactive (idle) levels of the
// five asynchronous inputs.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // Default number of synchronizer flops per asynchronous input (2..4).
    localparam int SYNC_STAGES_DEF = 2;

    // FSM state encoding: the state bit doubles as the mag_on output.
    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_ON  = 1'b1;

    // Idle levels the synchronizer flops clear to while in reset.
    localparam logic STARTN_IDLE = 1'b1;
    localparam logic STOPN_IDLE  = 1'b1;
    localparam logic CLEARN_IDLE = 1'b1;
    localparam logic DOOR_IDLE   = 1'b0;
    localparam logic DONE_IDLE   = 1'b0;

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for one asynchronous input bit.
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset; every flop loads RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output (STAGES edges behind i_d)
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/control.sv
// ---------------------------------------------------------------------------
// control
// Microwave magnetron control: synchronizes the five asynchronous inputs,
// decodes start/stop conditions and runs a two-state OFF/ON FSM. All three
// outputs are registered and update on the same edge.
// Ports:
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   startn      : start button, active-low, async
//   stopn       : stop/pause button, active-low, async
//   clearn      : clear button, active-low, async
//   door_closed : door sensor, 1 = closed, async
//   timer_done  : cook timer expired, active-high, async
//   set         : registered start_cond (latch-on request, level)
//   reset       : registered stop_cond (latch-off request, level)
//   mag_on      : registered FSM state, 1 = heating
// ---------------------------------------------------------------------------
module control
    import ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic startn,
    input  logic stopn,
    input  logic clearn,
    input  logic door_closed,
    input  logic timer_done,
    output logic set,
    output logic reset,
    output logic mag_on
);

    logic w_startn_s;
    logic w_stopn_s;
    logic w_clearn_s;
    logic w_door_s;
    logic w_done_s;

    logic w_stop_cond;
    logic w_start_cond;

    logic       r_set;
    logic       r_reset;
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(STARTN_IDLE)) u_sync_start (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(startn), .o_q(w_startn_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(STOPN_IDLE)) u_sync_stop (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(stopn), .o_q(w_stopn_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(CLEARN_IDLE)) u_sync_clear (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(clearn), .o_q(w_clearn_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(DOOR_IDLE)) u_sync_door (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(door_closed), .o_q(w_door_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(DONE_IDLE)) u_sync_done (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(timer_done), .o_q(w_done_s)
    );

    // Any stop source wins; start is masked by it so set and reset are
    // mutually exclusive by construction.
    assign w_stop_cond  = ~w_stopn_s | ~w_clearn_s | ~w_door_s | w_done_s;
    assign w_start_cond = ~w_startn_s & ~w_stop_cond;

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop_cond) begin
            w_state_nxt = ST_OFF;
        end else if (w_start_cond) begin
            w_state_nxt = ST_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_set   <= 1'b0;
            r_reset <= 1'b0;
            r_state <= ST_OFF;
        end else begin
            r_set   <= w_start_cond;
            r_reset <= w_stop_cond;
            r_state <= w_state_nxt;
        end
    end

    assign set    = r_set;
    assign reset  = r_reset;
    assign mag_on = r_state[0];

endmodule

// File: tb/tb_control.sv
module tb_control;
    import ctrl_pkg::*;

    localparam int S      = SYNC_STAGES_DEF;
    localparam int MAXE   = 4096;

    logic clk = 1'b0;
    logic rst_n, startn, stopn, clearn, door_closed, timer_done;
    logic set, reset, mag_on;

    control #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed), .timer_done(timer_done),
        .set(set), .reset(reset), .mag_on(mag_on)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic set;
        logic rst;
        logic mag;
    } exp_t;

    typedef struct packed {
        logic startn;
        logic stopn;
        logic clearn;
        logic door;
        logic done;
    } in_t;

    exp_t q[$];
    in_t  in_h  [0:MAXE-1];
    bit   rst_h [0:MAXE-1];
    int   edge_n = 0;
    bit   model_on = 1'b0;
    int   checks = 0;
    int   passed = 0;
    string phase = "init";

    // Inputs as seen by the decode logic at edge e: the value applied S
    // edges earlier, or the idle levels if a reset happened in between.
    function automatic in_t seen_at(int e);
        in_t v;
        bit any_rst = 1'b0;
        for (int k = 1; k <= S; k++) begin
            if (e - k < 0) any_rst = 1'b1;
            else if (rst_h[e-k]) any_rst = 1'b1;
        end
        if (any_rst) v = '{startn: 1'b1, stopn: 1'b1, clearn: 1'b1, door: 1'b0, done: 1'b0};
        else         v = in_h[e-S];
        return v;
    endfunction

    // Apply one cycle of inputs ahead of the next rising edge and predict
    // the outputs right after that edge.
    task automatic step(input bit r_n, input bit sn, input bit pn,
                        input bit cn, input bit d, input bit t);
        in_t  v;
        exp_t e;
        bit   stop_c, start_c;
        @(negedge clk);
        rst_n = r_n; startn = sn; stopn = pn; clearn = cn;
        door_closed = d; timer_done = t;
        in_h[edge_n]  = '{startn: sn, stopn: pn, clearn: cn, door: d, done: t};
        rst_h[edge_n] = !r_n;
        if (!r_n) begin
            model_on = 1'b0;
            e = '{set: 1'b0, rst: 1'b0, mag: 1'b0};
        end else begin
            v       = seen_at(edge_n);
            stop_c  = !v.stopn || !v.clearn || !v.door || v.done;
            start_c = !v.startn && !stop_c;
            if (stop_c)       model_on = 1'b0;
            else if (start_c) model_on = 1'b1;
            e = '{set: start_c, rst: stop_c, mag: model_on};
        end
        q.push_back(e);
        edge_n++;
    endtask

    task automatic hold(input int n, input bit r_n, input bit sn, input bit pn,
                        input bit cn, input bit d, input bit t);
        for (int i = 0; i < n; i++) step(r_n, sn, pn, cn, d, t);
    endtask

    // Monitor: every rising edge produces one output triple to check.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({set, reset, mag_on} === {e.set, e.rst, e.mag}) begin
                passed++;
            end else begin
                $display("FAIL %s edge: got set/reset/mag_on=%b%b%b required %b%b%b at t=%0t",
                         phase, set, reset, mag_on, e.set, e.rst, e.mag, $time);
            end
        end
    end

    initial begin
        rst_n = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b0; timer_done = 1'b0;

        phase = "reset";      hold(3,  0, 1, 1, 1, 0, 0);
        phase = "door_open";  hold(10, 1, 1, 1, 1, 0, 0);
        phase = "idle_closed";hold(5,  1, 1, 1, 1, 1, 0);
        phase = "start";      hold(6,  1, 0, 1, 1, 1, 0);
        phase = "stop_held";  hold(5,  1, 0, 0, 1, 1, 0);
        phase = "restart";    hold(5,  1, 0, 1, 1, 1, 0);
        phase = "clear_held"; hold(5,  1, 0, 1, 0, 1, 0);
        phase = "restart2";   hold(5,  1, 0, 1, 1, 1, 0);
        phase = "timer_done"; hold(5,  1, 0, 1, 1, 1, 1);
        phase = "restart3";   hold(5,  1, 0, 1, 1, 1, 0);
        phase = "door_on";    hold(5,  1, 0, 1, 1, 0, 0);
        phase = "release";    hold(5,  1, 1, 1, 1, 1, 0);
        phase = "start_stop"; hold(6,  1, 0, 0, 1, 1, 0);
        phase = "release2";   hold(4,  1, 1, 1, 1, 1, 0);
        phase = "on_again";   hold(6,  1, 0, 1, 1, 1, 0);
        phase = "mid_reset";  hold(1,  0, 0, 1, 1, 1, 0);
        phase = "after_rst";  hold(6,  1, 0, 1, 1, 1, 0);

        phase = "random";
        for (int i = 0; i < 120; i++) begin
            bit r_n, sn, pn, cn, d, t;
            int len;
            r_n = ($urandom_range(0, 29) != 0);
            sn  = ($urandom_range(0, 2) == 0);
            pn  = ($urandom_range(0, 5) != 0);
            cn  = ($urandom_range(0, 7) != 0);
            d   = ($urandom_range(0, 6) != 0);
            t   = ($urandom_range(0, 7) == 0);
            len = r_n ? $urandom_range(1, 6) : 1;
            hold(len, r_n, sn, pn, cn, d, t);
        end

        phase = "drain";
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expectations, required 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
